// File: rtl/spi_slave_port.sv
// SPI target oversampled on clk_cpu: deserialises MOSI frames into rx_data and
// serialises a preloaded reply word on MISO, with overrun/frame-error reporting.
module spi_slave_port #(
  parameter int DATA_W = 32,
  parameter bit CPOL   = 1'b0,
  parameter bit CPHA   = 1'b0
) (
  input  logic              clk_cpu,
  input  logic              rst,
  input  logic              SCK,
  input  logic              MOSI,
  input  logic              SS,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr,
  output logic              tx_empty,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    DONE    = 2'd2,
    WAIT_SS = 2'd3
  } state_t;

  state_t state_r, state_nxt;

  // [0],[1] form the synchroniser, [2] is the edge-detect delay stage
  logic [2:0] sck_r, ss_r, mosi_r;

  logic [DATA_W-1:0] tx_hold_r, tx_shift_r, rx_shift_r, rx_data_r;
  logic [CNT_W-1:0]  bitcnt_r;
  logic              tx_empty_r, rx_valid_r, overrun_r, frame_err_r, busy_r, miso_r;

  logic              lead_s, trail_s, sample_s, shift_s, ss_fall_s, ss_high_s;
  logic              load_s, sample_en_s, shift_en_s, abort_s, done_s, miso_nxt;
  logic [DATA_W-1:0] load_word_s;

  assign lead_s      = (sck_r[1] != CPOL) && (sck_r[2] == CPOL);
  assign trail_s     = (sck_r[1] == CPOL) && (sck_r[2] != CPOL);
  assign sample_s    = CPHA ? trail_s : lead_s;
  assign shift_s     = CPHA ? lead_s : trail_s;
  assign ss_fall_s   = !ss_r[1] && ss_r[2];
  assign ss_high_s   = ss_r[1];
  assign load_word_s = tx_empty_r ? {DATA_W{1'b0}} : tx_hold_r;

  // Pin synchronisers, preset to the idle bus levels
  always_ff @(posedge clk_cpu or negedge rst) begin
    if (!rst) begin
      sck_r  <= {3{CPOL}};
      ss_r   <= 3'b111;
      mosi_r <= 3'b000;
    end else begin
      sck_r  <= {sck_r[1:0], SCK};
      ss_r   <= {ss_r[1:0], SS};
      mosi_r <= {mosi_r[1:0], MOSI};
    end
  end

  // Frame sequencing: next state, datapath strobes and next MISO level
  always_comb begin
    state_nxt   = state_r;
    load_s      = 1'b0;
    sample_en_s = 1'b0;
    shift_en_s  = 1'b0;
    abort_s     = 1'b0;
    done_s      = 1'b0;
    miso_nxt    = miso_r;
    case (state_r)
      IDLE: begin
        if (ss_fall_s) begin
          load_s    = 1'b1;
          state_nxt = ACTIVE;
          miso_nxt  = CPHA ? 1'b0 : load_word_s[DATA_W-1];
        end else begin
          miso_nxt  = 1'b0;
        end
      end
      ACTIVE: begin
        if (ss_high_s) begin
          abort_s   = 1'b1;
          state_nxt = IDLE;
          miso_nxt  = 1'b0;
        end else if (sample_s) begin
          sample_en_s = 1'b1;
          state_nxt   = (bitcnt_r == CNT_LAST) ? DONE : ACTIVE;
        end else if (shift_s) begin
          shift_en_s = 1'b1;
          miso_nxt   = CPHA ? tx_shift_r[DATA_W-1] : tx_shift_r[DATA_W-2];
        end else begin
          state_nxt = ACTIVE;
        end
      end
      DONE: begin
        done_s    = 1'b1;
        miso_nxt  = 1'b0;
        state_nxt = WAIT_SS;
      end
      WAIT_SS: begin
        miso_nxt  = 1'b0;
        state_nxt = ss_high_s ? IDLE : WAIT_SS;
      end
      default: begin
        miso_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and registered status outputs
  always_ff @(posedge clk_cpu or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      miso_r      <= 1'b0;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      miso_r      <= miso_nxt;
      busy_r      <= (state_nxt != IDLE);
      frame_err_r <= abort_s;
    end
  end

  // Shift registers and bit counter
  always_ff @(posedge clk_cpu or negedge rst) begin
    if (!rst) begin
      tx_shift_r <= {DATA_W{1'b0}};
      rx_shift_r <= {DATA_W{1'b0}};
      bitcnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (load_s) begin
        tx_shift_r <= load_word_s;
        bitcnt_r   <= {CNT_W{1'b0}};
      end else if (shift_en_s) begin
        tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
      end else if (sample_en_s) begin
        rx_shift_r <= {rx_shift_r[DATA_W-2:0], mosi_r[2]};
        bitcnt_r   <= bitcnt_r + CNT_W'(1);
      end else begin
        bitcnt_r   <= bitcnt_r;
      end
    end
  end

  // Host handshakes; a write always wins over the consume-on-load
  always_ff @(posedge clk_cpu or negedge rst) begin
    if (!rst) begin
      tx_hold_r  <= {DATA_W{1'b0}};
      tx_empty_r <= 1'b1;
      rx_data_r  <= {DATA_W{1'b0}};
      rx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      if (tx_wr) begin
        tx_hold_r  <= tx_data;
        tx_empty_r <= 1'b0;
      end else if (load_s) begin
        tx_empty_r <= 1'b1;
      end else begin
        tx_empty_r <= tx_empty_r;
      end
      if (done_s) begin
        rx_data_r  <= rx_shift_r;
        rx_valid_r <= 1'b1;
        if (rx_valid_r && !rx_ack) begin
          overrun_r <= 1'b1;
        end else begin
          overrun_r <= overrun_r;
        end
      end else if (rx_ack) begin
        rx_valid_r <= 1'b0;
        overrun_r  <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
    end
  end

  assign MISO      = miso_r;
  assign tx_empty  = tx_empty_r;
  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign overrun   = overrun_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: a mode-0 and a mode-3 instance driven by a bit-level
// master, checked against a frame-level model of the host-visible state.
module tb_spi_slave_port;

  logic clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  logic        rst;
  logic        sck0, mosi0, ss0, miso0, sck1, mosi1, ss1, miso1;
  logic [31:0] tx_data0, tx_data1, rx_data0, rx_data1;
  logic        tx_wr0, tx_wr1, tx_empty0, tx_empty1, rx_valid0, rx_valid1;
  logic        rx_ack0, rx_ack1, ovr0, ovr1, fe0, fe1, busy0, busy1;

  spi_slave_port #(.DATA_W(32), .CPOL(1'b0), .CPHA(1'b0)) u0 (
    .clk_cpu(clk_cpu), .rst(rst), .SCK(sck0), .MOSI(mosi0), .SS(ss0), .MISO(miso0),
    .tx_data(tx_data0), .tx_wr(tx_wr0), .tx_empty(tx_empty0), .rx_data(rx_data0),
    .rx_valid(rx_valid0), .rx_ack(rx_ack0), .overrun(ovr0), .frame_err(fe0), .busy(busy0));

  spi_slave_port #(.DATA_W(32), .CPOL(1'b1), .CPHA(1'b1)) u1 (
    .clk_cpu(clk_cpu), .rst(rst), .SCK(sck1), .MOSI(mosi1), .SS(ss1), .MISO(miso1),
    .tx_data(tx_data1), .tx_wr(tx_wr1), .tx_empty(tx_empty1), .rx_data(rx_data1),
    .rx_valid(rx_valid1), .rx_ack(rx_ack1), .overrun(ovr1), .frame_err(fe1), .busy(busy1));

  // frame-level model of what the host should see
  logic [31:0] m_rx[2], m_hold[2];
  logic        m_valid[2], m_ovr[2], m_empty[2];
  int          errors = 0, checks = 0;
  bit          chk_en = 1'b0;
  int          fe_hi[2] = '{0, 0};

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input int i, input logic act, input logic exp);
    check(name, i, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic logic [31:0] d_rx(input int i);    return (i == 0) ? rx_data0 : rx_data1; endfunction
  function automatic logic d_valid(input int i); return (i == 0) ? rx_valid0 : rx_valid1; endfunction
  function automatic logic d_ovr(input int i);   return (i == 0) ? ovr0 : ovr1; endfunction
  function automatic logic d_empty(input int i); return (i == 0) ? tx_empty0 : tx_empty1; endfunction
  function automatic logic d_busy(input int i);  return (i == 0) ? busy0 : busy1; endfunction
  function automatic logic d_fe(input int i);    return (i == 0) ? fe0 : fe1; endfunction
  function automatic logic d_miso(input int i);  return (i == 0) ? miso0 : miso1; endfunction

  task automatic set_sck(input int i, input logic v);  if (i == 0) sck0 = v;  else sck1 = v;  endtask
  task automatic set_mosi(input int i, input logic v); if (i == 0) mosi0 = v; else mosi1 = v; endtask
  task automatic set_ss(input int i, input logic v);   if (i == 0) ss0 = v;   else ss1 = v;   endtask
  task automatic set_ack(input int i, input logic v);  if (i == 0) rx_ack0 = v; else rx_ack1 = v; endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_cpu);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rx[i] = 32'h0; m_hold[i] = 32'h0;
      m_valid[i] = 1'b0; m_ovr[i] = 1'b0; m_empty[i] = 1'b1;
    end
  endtask

  task automatic do_wr(input int i, input logic [31:0] d);
    if (i == 0) begin tx_data0 = d; tx_wr0 = 1'b1; end
    else begin tx_data1 = d; tx_wr1 = 1'b1; end
    m_hold[i] = d; m_empty[i] = 1'b0;
    cyc(1);
    tx_wr0 = 1'b0; tx_wr1 = 1'b0;
  endtask

  task automatic do_ack(input int i);
    set_ack(i, 1'b1);
    m_valid[i] = 1'b0; m_ovr[i] = 1'b0;
    cyc(1);
    set_ack(i, 1'b0);
  endtask

  // called right after the pin edge carrying the last sample; spans one half-period
  task automatic done_wait(input int i, input logic [31:0] w, input bit coin_ack);
    logic pre;
    pre = m_valid[i];
    cyc(3);
    check1("valid_before_done", i, d_valid(i), pre);
    if (coin_ack) set_ack(i, 1'b1);
    cyc(1);
    set_ack(i, 1'b0);
    if (!coin_ack) m_ovr[i] = m_ovr[i] | m_valid[i];
    m_valid[i] = 1'b1;
    m_rx[i] = w;
    check1("valid_after_done", i, d_valid(i), 1'b1);
    check("rx_data_done", i, d_rx(i), w);
    check1("overrun_done", i, d_ovr(i), m_ovr[i]);
    cyc(1);
  endtask

  // master side of one frame, half-period 5 clk_cpu cycles
  task automatic xfer(input int i, input logic [31:0] w, input int nbits, input bit coin_ack,
                      input bit wr_ld, input logic [31:0] wr_val, input bit do_rst,
                      output logic [31:0] got);
    logic cpol, cpha;
    logic [31:0] reply;
    int fe_start;
    cpol = (i == 1); cpha = (i == 1);
    chk_en = 1'b0;
    got = 32'h0;
    fe_start = fe_hi[i];
    reply = m_empty[i] ? 32'h0 : m_hold[i];
    m_empty[i] = 1'b1;
    set_ss(i, 1'b0);
    if (!cpha) set_mosi(i, w[31]);
    if (wr_ld) begin
      cyc(2);
      if (i == 0) begin tx_data0 = wr_val; tx_wr0 = 1'b1; end
      else begin tx_data1 = wr_val; tx_wr1 = 1'b1; end
      m_hold[i] = wr_val; m_empty[i] = 1'b0;
      cyc(1);
      tx_wr0 = 1'b0; tx_wr1 = 1'b0;
      cyc(2);
    end else begin
      cyc(5);
    end
    for (int b = 0; b < nbits; b++) begin
      set_sck(i, ~cpol);
      if (cpha) set_mosi(i, w[31-b]);
      else got[31-b] = d_miso(i);
      if (!cpha && b == 31) done_wait(i, w, coin_ack);
      else cyc(5);
      set_sck(i, cpol);
      if (cpha) got[31-b] = d_miso(i);
      else if (b < 31) set_mosi(i, w[30-b]);
      if (cpha && b == 31) done_wait(i, w, coin_ack);
      else cyc(5);
    end
    if (do_rst) begin
      rst = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
        check("rst_rx_data", k, d_rx(k), 32'h0);
        check1("rst_rx_valid", k, d_valid(k), 1'b0);
        check1("rst_overrun", k, d_ovr(k), 1'b0);
        check1("rst_tx_empty", k, d_empty(k), 1'b1);
        check1("rst_busy", k, d_busy(k), 1'b0);
        check1("rst_frame_err", k, d_fe(k), 1'b0);
        check1("rst_miso", k, d_miso(k), 1'b0);
      end
      sck0 = 1'b0; ss0 = 1'b1; mosi0 = 1'b0;
      sck1 = 1'b1; ss1 = 1'b1; mosi1 = 1'b0;
      cyc(2);
      rst = 1'b1;
      cyc(2);
    end
    set_ss(i, 1'b1);
    set_mosi(i, 1'b0);
    cyc(8);
    if (nbits < 32 && !do_rst) check("frame_err_pulse_cycles", i, 32'(fe_hi[i] - fe_start), 32'd1);
    if (nbits == 32) check("miso_stream", i, got, reply);
    chk_en = 1'b1;
  endtask

  // compare process: host-visible outputs against the model whenever the bus is idle
  always @(posedge clk_cpu) begin
    #1;
    fe_hi[0] += 32'(fe0);
    fe_hi[1] += 32'(fe1);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check("rx_data", i, d_rx(i), m_rx[i]);
        check1("rx_valid", i, d_valid(i), m_valid[i]);
        check1("overrun", i, d_ovr(i), m_ovr[i]);
        check1("tx_empty", i, d_empty(i), m_empty[i]);
        check1("busy_idle", i, d_busy(i), 1'b0);
        check1("frame_err_idle", i, d_fe(i), 1'b0);
        check1("miso_idle", i, d_miso(i), 1'b0);
      end
    end
  end

  initial begin
    logic [31:0] got, w, v;
    int i, kind, nb;
    rst = 1'b0;
    sck0 = 1'b0; ss0 = 1'b1; mosi0 = 1'b0;
    sck1 = 1'b1; ss1 = 1'b1; mosi1 = 1'b0;
    tx_data0 = 32'h0; tx_data1 = 32'h0; tx_wr0 = 1'b0; tx_wr1 = 1'b0;
    rx_ack0 = 1'b0; rx_ack1 = 1'b0;
    model_reset();
    cyc(2);
    chk_en = 1'b1;
    cyc(2);
    check1("reset_tx_empty_lit", 0, tx_empty0, 1'b1);
    rst = 1'b1;
    cyc(3);

    // mode 0 basic frame
    do_wr(0, 32'hA5A5_0F0F);
    xfer(0, 32'h0000_0009, 32, 1'b0, 1'b0, 32'h0, 1'b0, got);
    check("t1_miso_lit", 0, got, 32'hA5A5_0F0F);
    check("t1_rx_lit", 0, rx_data0, 32'h0000_0009);
    check1("t1_empty_lit", 0, tx_empty0, 1'b1);

    // back-to-back frames without ack
    do_ack(0);
    xfer(0, 32'h1, 32, 1'b0, 1'b0, 32'h0, 1'b0, got);
    xfer(0, 32'h2, 32, 1'b0, 1'b0, 32'h0, 1'b0, got);
    check1("t2_ovr_lit", 0, ovr0, 1'b1);
    check("t2_rx_lit", 0, rx_data0, 32'h2);
    check1("t2_valid_lit", 0, rx_valid0, 1'b1);
    do_ack(0);
    cyc(1);
    check1("t2_ack_valid_lit", 0, rx_valid0, 1'b0);
    check1("t2_ack_ovr_lit", 0, ovr0, 1'b0);

    // aborted frame, then a good one
    xfer(0, 32'h1234_5678, 10, 1'b0, 1'b0, 32'h0, 1'b0, got);
    check1("t3_valid_lit", 0, rx_valid0, 1'b0);
    xfer(0, 32'hDEAD_BEEF, 32, 1'b0, 1'b0, 32'h0, 1'b0, got);
    check("t3_rx_lit", 0, rx_data0, 32'hDEAD_BEEF);
    do_ack(0);

    // CPOL=1 CPHA=1
    do_wr(1, 32'h0000_0003);
    xfer(1, 32'h8000_0001, 32, 1'b0, 1'b0, 32'h0, 1'b0, got);
    check("t4_miso_lit", 1, got, 32'h0000_0003);
    check("t4_rx_lit", 1, rx_data1, 32'h8000_0001);

    // reset mid-frame at bit 17, then a clean frame
    do_wr(0, 32'h0BAD_F00D);
    xfer(0, 32'h7777_1111, 17, 1'b0, 1'b0, 32'h0, 1'b1, got);
    xfer(0, 32'hCAFE_F00D, 32, 1'b0, 1'b0, 32'h0, 1'b0, got);
    check("t5_rx_lit", 0, rx_data0, 32'hCAFE_F00D);
    check("t5_miso_lit", 0, got, 32'h0);

    // ack coincident with DONE while rx_valid=1
    do_ack(0);
    xfer(0, 32'h1111_1111, 32, 1'b0, 1'b0, 32'h0, 1'b0, got);
    xfer(0, 32'h2222_2222, 32, 1'b1, 1'b0, 32'h0, 1'b0, got);
    check1("t6_valid_lit", 0, rx_valid0, 1'b1);
    check1("t6_ovr_lit", 0, ovr0, 1'b0);
    check("t6_rx_lit", 0, rx_data0, 32'h2222_2222);

    // tx_wr landing on the load cycle
    do_wr(0, 32'h0F0F_F0F0);
    xfer(0, 32'h3333_4444, 32, 1'b0, 1'b1, 32'h5A5A_5A5A, 1'b0, got);
    check("t7_miso_lit", 0, got, 32'h0F0F_F0F0);
    check1("t7_empty_lit", 0, tx_empty0, 1'b0);
    xfer(0, 32'h5555_6666, 32, 1'b0, 1'b0, 32'h0, 1'b0, got);
    check("t7_next_miso_lit", 0, got, 32'h5A5A_5A5A);

    // randomized frames on both instances
    for (int n = 0; n < 24; n++) begin
      i = int'($urandom_range(1, 0));
      w = $urandom;
      v = $urandom;
      if ($urandom_range(1, 0) == 1) do_wr(i, $urandom);
      if ($urandom_range(2, 0) == 0) do_ack(i);
      kind = int'($urandom_range(7, 0));
      nb = (kind == 0) ? int'($urandom_range(31, 1)) : 32;
      xfer(i, w, nb, (kind == 1), (kind == 2), v, 1'b0, got);
    end
    cyc(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
